// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: decodes a MIPS instruction into ALU control and
// operands, registers them with stall/flush, and keeps a second control
// register aligned with the ALU result for the MEM stage.
module id_ex_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [31:0]           instr,
  input  logic [DATA_W-1:0]     rs_data,
  input  logic [DATA_W-1:0]     rt_data,
  input  logic [1:0]            fwd_a_sel,
  input  logic [1:0]            fwd_b_sel,
  input  logic [DATA_W-1:0]     ex_fwd,
  input  logic [DATA_W-1:0]     mem_fwd,
  output logic                  ex_valid,
  output logic [3:0]            alu_ctrl,
  output logic [DATA_W-1:0]     alu_data1,
  output logic [DATA_W-1:0]     alu_data2,
  output logic [4:0]            alu_shamt,
  output logic                  illegal,
  output logic                  res_valid,
  output logic [REG_ADDR_W-1:0] res_dest,
  output logic                  res_reg_write,
  output logic                  res_mem_read,
  output logic                  res_mem_write,
  output logic                  res_branch,
  output logic [DATA_W-1:0]     res_store_data
);

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_SLL  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_SRA  = 4'b0110,
    ALU_GT   = 4'b0111,
    ALU_LESS = 4'b1000
  } alu_op_e;

  logic [5:0]            w_op, w_funct;
  logic [DATA_W-1:0]     w_a, w_b, w_se, w_ze;
  alu_op_e               w_ctrl;
  logic [DATA_W-1:0]     w_d1, w_d2;
  logic [4:0]            w_shamt;
  logic                  w_ill, w_rw, w_mr, w_mw, w_br;
  logic [REG_ADDR_W-1:0] w_dest;

  // ID/EX register fields (controls kept internally for the result stage)
  logic                  r_fresh;
  logic [REG_ADDR_W-1:0] r_dest;
  logic                  r_rw, r_mr, r_mw, r_br;
  logic [DATA_W-1:0]     r_store;

  assign w_op    = instr[31:26];
  assign w_funct = instr[5:0];
  assign w_se    = {{(DATA_W-16){instr[15]}}, instr[15:0]};
  assign w_ze    = {{(DATA_W-16){1'b0}}, instr[15:0]};

  // Forwarding muxes for the rs and rt operands
  always_comb begin
    unique case (fwd_a_sel)
      2'b01:   w_a = ex_fwd;
      2'b10:   w_a = mem_fwd;
      default: w_a = rs_data;
    endcase
    unique case (fwd_b_sel)
      2'b01:   w_b = ex_fwd;
      2'b10:   w_b = mem_fwd;
      default: w_b = rt_data;
    endcase
  end

  // Instruction decode into ALU control, operands and pipeline controls
  always_comb begin
    w_ctrl  = ALU_ADD;
    w_d1    = w_a;
    w_d2    = w_b;
    w_shamt = '0;
    w_ill   = 1'b0;
    w_dest  = instr[15:11];
    w_rw    = 1'b0;
    w_mr    = 1'b0;
    w_mw    = 1'b0;
    w_br    = 1'b0;
    if (w_op == 6'h00) begin
      w_rw = 1'b1;
      case (w_funct)
        6'h20, 6'h21: w_ctrl = ALU_ADD;
        6'h22, 6'h23: w_ctrl = ALU_SUB;
        6'h24:        w_ctrl = ALU_AND;
        6'h25:        w_ctrl = ALU_OR;
        6'h2A:        w_ctrl = ALU_LESS;
        6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07: begin
          // shifts operate on rt; the amount is immediate or from rs[4:0]
          unique case (w_funct[1:0])
            2'b00:   w_ctrl = ALU_SLL;
            2'b10:   w_ctrl = ALU_SRL;
            default: w_ctrl = ALU_SRA;
          endcase
          w_d1    = w_b;
          w_d2    = '0;
          w_shamt = w_funct[2] ? w_a[4:0] : instr[10:6];
        end
        default: begin
          w_ill = 1'b1;
          w_rw  = 1'b0;
        end
      endcase
    end else begin
      w_dest = instr[20:16];
      case (w_op)
        6'h08, 6'h09: begin w_d2 = w_se; w_rw = 1'b1; end
        6'h0A: begin w_ctrl = ALU_LESS; w_d2 = w_se; w_rw = 1'b1; end
        6'h0C: begin w_ctrl = ALU_AND;  w_d2 = w_ze; w_rw = 1'b1; end
        6'h0D: begin w_ctrl = ALU_OR;   w_d2 = w_ze; w_rw = 1'b1; end
        6'h23: begin w_d2 = w_se; w_rw = 1'b1; w_mr = 1'b1; end
        6'h2B: begin w_d2 = w_se; w_mw = 1'b1; end
        6'h04: begin w_ctrl = ALU_SUB; w_br = 1'b1; end
        default: w_ill = 1'b1;
      endcase
    end
  end

  // ID/EX register: reset > flush > stall > load
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid  <= 1'b0;
      alu_ctrl  <= '0;
      alu_data1 <= '0;
      alu_data2 <= '0;
      alu_shamt <= '0;
      illegal   <= 1'b0;
      r_fresh   <= 1'b0;
      r_dest    <= '0;
      r_rw      <= 1'b0;
      r_mr      <= 1'b0;
      r_mw      <= 1'b0;
      r_br      <= 1'b0;
      r_store   <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
      illegal  <= 1'b0;
      r_fresh  <= 1'b1;
      r_dest   <= '0;
      r_rw     <= 1'b0;
      r_mr     <= 1'b0;
      r_mw     <= 1'b0;
      r_br     <= 1'b0;
    end else if (stall) begin
      r_fresh <= 1'b0;
    end else begin
      // controls are gated by in_valid so a bubble never carries write enables
      ex_valid  <= in_valid;
      alu_ctrl  <= w_ctrl;
      alu_data1 <= w_d1;
      alu_data2 <= w_d2;
      alu_shamt <= w_shamt;
      illegal   <= in_valid & w_ill;
      r_fresh   <= 1'b1;
      r_dest    <= w_dest;
      r_rw      <= in_valid & w_rw;
      r_mr      <= in_valid & w_mr;
      r_mw      <= in_valid & w_mw;
      r_br      <= in_valid & w_br;
      r_store   <= w_b;
    end
  end

  // Result-aligned control register; a held instruction is presented once
  always_ff @(posedge clk) begin
    if (reset) begin
      res_valid      <= 1'b0;
      res_dest       <= '0;
      res_reg_write  <= 1'b0;
      res_mem_read   <= 1'b0;
      res_mem_write  <= 1'b0;
      res_branch     <= 1'b0;
      res_store_data <= '0;
    end else begin
      res_valid      <= ex_valid & r_fresh;
      res_dest       <= r_dest;
      res_reg_write  <= r_rw;
      res_mem_read   <= r_mr;
      res_mem_write  <= r_mw;
      res_branch     <= r_br;
      res_store_data <= r_store;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage.
module tb_id_ex_stage;
  logic        clk = 1'b0;
  logic        reset, in_valid, stall, flush;
  logic [31:0] instr, rs_data, rt_data, ex_fwd, mem_fwd;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic        ex_valid, illegal, res_valid, res_reg_write, res_mem_read, res_mem_write, res_branch;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_data1, alu_data2, res_store_data;
  logic [4:0]  alu_shamt, res_dest;
  int          n_checks = 0;
  int          n_fail = 0;

  id_ex_stage #(.DATA_W(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
    .instr(instr), .rs_data(rs_data), .rt_data(rt_data),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .ex_fwd(ex_fwd), .mem_fwd(mem_fwd),
    .ex_valid(ex_valid), .alu_ctrl(alu_ctrl), .alu_data1(alu_data1), .alu_data2(alu_data2),
    .alu_shamt(alu_shamt), .illegal(illegal), .res_valid(res_valid), .res_dest(res_dest),
    .res_reg_write(res_reg_write), .res_mem_read(res_mem_read), .res_mem_write(res_mem_write),
    .res_branch(res_branch), .res_store_data(res_store_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; stall = 1'b0; flush = 1'b0; instr = '0;
    rs_data = '0; rt_data = '0; ex_fwd = '0; mem_fwd = '0; fwd_a_sel = 2'b00; fwd_b_sel = 2'b00;
    tick(); tick();
    n_checks++;
    if ({ex_valid, alu_ctrl, alu_data1, alu_data2, alu_shamt, illegal} !== '0) begin
      n_fail++; $display("FAIL reset_ex: got %h expected 0", {ex_valid, alu_ctrl, alu_data1, alu_data2, alu_shamt, illegal});
    end
    n_checks++;
    if ({res_valid, res_dest, res_reg_write, res_mem_read, res_mem_write, res_branch, res_store_data} !== '0) begin
      n_fail++; $display("FAIL reset_res: got %h expected 0", {res_valid, res_dest, res_reg_write, res_mem_read, res_mem_write, res_branch, res_store_data});
    end
    reset = 1'b0;
  endtask

  task automatic test_addi();
    instr = 32'h2128FFFC; rs_data = 32'd10; in_valid = 1'b1;
    tick();
    n_checks++;
    if ({ex_valid, alu_ctrl} !== 5'b1_0000) begin n_fail++; $display("FAIL addi_ctrl: got %b expected 10000", {ex_valid, alu_ctrl}); end
    n_checks++;
    if (alu_data1 !== 32'd10) begin n_fail++; $display("FAIL addi_d1: got %h expected 0000000a", alu_data1); end
    n_checks++;
    if (alu_data2 !== 32'hFFFFFFFC) begin n_fail++; $display("FAIL addi_d2: got %h expected fffffffc", alu_data2); end
    n_checks++;
    if (res_valid !== 1'b0) begin n_fail++; $display("FAIL addi_res_early: got %b expected 0", res_valid); end
    in_valid = 1'b0;
    tick();
    n_checks++;
    if ({res_valid, res_dest, res_reg_write, res_mem_read, res_mem_write, res_branch} !== {1'b1, 5'd8, 4'b1000}) begin
      n_fail++; $display("FAIL addi_res: got %b expected %b", {res_valid, res_dest, res_reg_write, res_mem_read, res_mem_write, res_branch}, {1'b1, 5'd8, 4'b1000});
    end
  endtask

  task automatic test_ori_sra();
    instr = 32'h34038001; rs_data = 32'h12345678; in_valid = 1'b1;
    tick();
    n_checks++;
    if ({alu_ctrl, alu_data2, alu_shamt} !== {4'b0011, 32'h00008001, 5'd0}) begin
      n_fail++; $display("FAIL ori: got %h expected %h", {alu_ctrl, alu_data2, alu_shamt}, {4'b0011, 32'h00008001, 5'd0});
    end
    instr = 32'h000511C3; rt_data = 32'h80000000;
    tick();
    n_checks++;
    if ({alu_ctrl, alu_data1, alu_shamt} !== {4'b0110, 32'h80000000, 5'd7}) begin
      n_fail++; $display("FAIL sra: got %h expected %h", {alu_ctrl, alu_data1, alu_shamt}, {4'b0110, 32'h80000000, 5'd7});
    end
    n_checks++;
    if ({res_valid, res_dest, res_reg_write} !== {1'b1, 5'd3, 1'b1}) begin
      n_fail++; $display("FAIL ori_res: got %b expected 1000111", {res_valid, res_dest, res_reg_write});
    end
    // variable shift: shamt from A[4:0] with A taken from mem_fwd
    instr = 32'h00430804; fwd_a_sel = 2'b10; mem_fwd = 32'h00000025; rt_data = 32'h0000000F;
    tick();
    n_checks++;
    if ({alu_ctrl, alu_data1, alu_shamt} !== {4'b0100, 32'h0000000F, 5'd5}) begin
      n_fail++; $display("FAIL sllv: got %h expected %h", {alu_ctrl, alu_data1, alu_shamt}, {4'b0100, 32'h0000000F, 5'd5});
    end
    fwd_a_sel = 2'b00; in_valid = 1'b0;
    tick();
  endtask

  task automatic test_sw_beq();
    instr = 32'hACC4000C; fwd_b_sel = 2'b01; ex_fwd = 32'hDEADBEEF; rs_data = 32'h100; in_valid = 1'b1;
    tick();
    n_checks++;
    if ({alu_ctrl, alu_data1, alu_data2} !== {4'b0000, 32'h100, 32'd12}) begin
      n_fail++; $display("FAIL sw_ex: got %h expected %h", {alu_ctrl, alu_data1, alu_data2}, {4'b0000, 32'h100, 32'd12});
    end
    // beq $1,$2 with A via fwd_a_sel=11 (rs_data) and B via rt_data
    instr = 32'h10220003; fwd_a_sel = 2'b11; fwd_b_sel = 2'b00; rs_data = 32'd9; rt_data = 32'd4;
    tick();
    n_checks++;
    if ({res_valid, res_mem_write, res_reg_write, res_store_data} !== {3'b110, 32'hDEADBEEF}) begin
      n_fail++; $display("FAIL sw_res: got %h expected %h", {res_valid, res_mem_write, res_reg_write, res_store_data}, {3'b110, 32'hDEADBEEF});
    end
    n_checks++;
    if ({alu_ctrl, alu_data1, alu_data2} !== {4'b0001, 32'd9, 32'd4}) begin
      n_fail++; $display("FAIL beq_ex: got %h expected %h", {alu_ctrl, alu_data1, alu_data2}, {4'b0001, 32'd9, 32'd4});
    end
    fwd_a_sel = 2'b00; in_valid = 1'b0;
    tick();
    n_checks++;
    if ({res_valid, res_branch, res_reg_write, res_mem_write} !== 4'b1100) begin
      n_fail++; $display("FAIL beq_res: got %b expected 1100", {res_valid, res_branch, res_reg_write, res_mem_write});
    end
  endtask

  task automatic test_stall();
    int seen;
    instr = 32'h00430820; rs_data = 32'd5; rt_data = 32'd7; in_valid = 1'b1;
    tick();
    // different instruction presented while held
    stall = 1'b1; instr = 32'h34038001; rs_data = 32'd99;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({ex_valid, alu_ctrl, alu_data1, alu_data2} !== {1'b1, 4'b0000, 32'd5, 32'd7}) begin
        n_fail++; $display("FAIL stall_hold%0d: got %h expected %h", i, {ex_valid, alu_ctrl, alu_data1, alu_data2}, {1'b1, 4'b0000, 32'd5, 32'd7});
      end
      if (res_valid === 1'b1) seen++;
      if (i == 0) begin
        n_checks++;
        if ({res_valid, res_dest} !== {1'b1, 5'd1}) begin
          n_fail++; $display("FAIL stall_first: got %b expected 100001", {res_valid, res_dest});
        end
      end
    end
    stall = 1'b0; in_valid = 1'b0;
    tick();
    if (res_valid === 1'b1) seen++;
    n_checks++;
    if (seen !== 1) begin n_fail++; $display("FAIL stall_once: got %0d presentations expected 1", seen); end
  endtask

  task automatic test_flush();
    instr = 32'h8C270004; in_valid = 1'b1; flush = 1'b1; stall = 1'b1;
    tick();
    n_checks++;
    if ({ex_valid, illegal} !== 2'b00) begin n_fail++; $display("FAIL flush_ex: got %b expected 00", {ex_valid, illegal}); end
    flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
    tick();
    n_checks++;
    if ({res_valid, res_mem_read, res_reg_write} !== 3'b000) begin
      n_fail++; $display("FAIL flush_res: got %b expected 000", {res_valid, res_mem_read, res_reg_write});
    end
  endtask

  task automatic test_illegal_reset();
    instr = 32'hFC000000; in_valid = 1'b1;
    tick();
    n_checks++;
    if ({illegal, ex_valid, alu_ctrl} !== 6'b11_0000) begin
      n_fail++; $display("FAIL illegal_ex: got %b expected 110000", {illegal, ex_valid, alu_ctrl});
    end
    instr = 32'h00430820; rs_data = 32'd3; rt_data = 32'd4;
    tick();
    n_checks++;
    if ({res_valid, res_reg_write, res_mem_read, res_mem_write, res_branch} !== 5'b10000) begin
      n_fail++; $display("FAIL illegal_res: got %b expected 10000", {res_valid, res_reg_write, res_mem_read, res_mem_write, res_branch});
    end
    reset = 1'b1;
    tick();
    n_checks++;
    if ({ex_valid, alu_ctrl, alu_data1, alu_data2, alu_shamt, illegal, res_valid, res_dest,
         res_reg_write, res_mem_read, res_mem_write, res_branch, res_store_data} !== '0) begin
      n_fail++; $display("FAIL midreset: outputs not all zero, ex_valid=%b res_valid=%b d1=%h", ex_valid, res_valid, alu_data1);
    end
    reset = 1'b0;
    tick();
    n_checks++;
    if ({ex_valid, res_valid} !== 2'b10) begin
      n_fail++; $display("FAIL post_reset1: got %b expected 10", {ex_valid, res_valid});
    end
    in_valid = 1'b0;
    tick();
    n_checks++;
    if ({res_valid, res_dest} !== {1'b1, 5'd1}) begin
      n_fail++; $display("FAIL post_reset2: got %b expected 100001", {res_valid, res_dest});
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_ori_sra();
    test_sw_beq();
    test_stall();
    test_flush();
    test_illegal_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
